// File: rtl/pixel_scan_controller.sv
// Raster scan controller: walks the (hCount, vCount) beam position at the pixel-tick rate,
// registers colour, sync and blanking together, and pulses frameDone once per frame.
module pixel_scan_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixelTick,
  input  logic [7:0]         pixelIn,
  output logic signed [15:0] nextX,
  output logic signed [15:0] nextY,
  output logic [7:0]         pixelColour,
  output logic               hSync,
  output logic               vSync,
  output logic               videoActive,
  output logic               frameDone
);

  localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int MAX_TOTAL   = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
  localparam int CW          = $clog2(MAX_TOTAL);
  localparam int H_SYNC_BEG  = H_ACTIVE + H_FP;
  localparam int H_SYNC_END  = H_ACTIVE + H_FP + H_SYNC;
  localparam int V_SYNC_BEG  = V_ACTIVE + V_FP;
  localparam int V_SYNC_END  = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // The coordinate ports are 16-bit signed, so the counters must leave the sign bit clear.
  if (CW > 15) begin : g_width_check
    $error("pixel_scan_controller: counter width %0d exceeds 15 bits", CW);
  end

  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  logic          h_wrap;
  logic          v_wrap;
  logic          active;
  logic          in_hsync;
  logic          in_vsync;

  // Window decode is done at 32 bits so a sync end equal to the total cannot overflow CW.
  always_comb begin
    h_wrap   = (h_count == H_LAST);
    v_wrap   = (v_count == V_LAST);
    active   = (32'(h_count) < H_ACTIVE) && (32'(v_count) < V_ACTIVE);
    in_hsync = (32'(h_count) >= H_SYNC_BEG) && (32'(h_count) < H_SYNC_END);
    in_vsync = (32'(v_count) >= V_SYNC_BEG) && (32'(v_count) < V_SYNC_END);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (pixelTick) begin
      h_count <= h_wrap ? '0 : h_count + 1'b1;
      if (h_wrap) begin
        v_count <= v_wrap ? '0 : v_count + 1'b1;
      end
    end
  end

  // Output stage registers the values for the coordinate presented before this edge,
  // giving every display output the same one-tick latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixelColour <= '0;
      videoActive <= 1'b0;
      hSync       <= ~SYNC_POL;
      vSync       <= ~SYNC_POL;
      frameDone   <= 1'b0;
    end else begin
      // Reloaded on every clk so the pulse is one clk wide even if the next cycle has no tick.
      frameDone <= pixelTick && h_wrap && v_wrap;
      if (pixelTick) begin
        pixelColour <= active ? pixelIn : 8'h00;
        videoActive <= active;
        hSync       <= in_hsync ? SYNC_POL : ~SYNC_POL;
        vSync       <= in_vsync ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

  assign nextX = {{(16-CW){1'b0}}, h_count};
  assign nextY = {{(16-CW){1'b0}}, v_count};

endmodule

// File: tb/tb_pixel_scan_controller.sv
// Scoreboard bench: a small-geometry and a default 640x480 controller run side by side;
// the driver queues predicted outputs per tick and per-instance monitors compare them.
module tb_pixel_scan_controller;

  typedef struct packed {
    int ha, hfp, hsy, hbp, va, vfp, vsy, vbp;
  } geom_t;

  typedef struct packed {
    logic [7:0]  colour;
    logic        vact;
    logic        hs;
    logic        vs;
    logic        fd;
    logic [15:0] x;
    logic [15:0] y;
  } exp_t;

  localparam geom_t G_S = '{8, 2, 3, 2, 4, 1, 2, 1};
  localparam geom_t G_B = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam exp_t  RST_EXP = '{colour: 8'h00, vact: 1'b0, hs: 1'b1, vs: 1'b1,
                                fd: 1'b0, x: 16'd0, y: 16'd0};

  logic clk = 1'b0;
  logic reset;
  logic pixel_tick;
  logic pix_mode;

  logic [7:0]         pix_s, pix_b, colour_s, colour_b;
  logic signed [15:0] next_x_s, next_y_s, next_x_b, next_y_b;
  logic               hs_s, vs_s, act_s, fd_s, hs_b, vs_b, act_b, fd_b;

  int   checks = 0;
  int   errors = 0;
  int   fd_cnt_s = 0;
  int   h_s, v_s, h_b, v_b;
  exp_t q_s[$];
  exp_t q_b[$];
  exp_t last_s, last_b, e_s, e_b;
  logic t_s, t_b;

  always #5 clk = ~clk;

  function automatic logic [7:0] gen_pix(input int x, input int y);
    return 8'((x * 3) ^ (y * 5) ^ 8'h3C);
  endfunction

  // Combinational pixel generator, answering for whatever coordinate each DUT presents.
  assign pix_s = pix_mode ? gen_pix(int'(next_x_s), int'(next_y_s)) : 8'hA5;
  assign pix_b = gen_pix(int'(next_x_b), int'(next_y_b));

  pixel_scan_controller #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_s (
    .clk(clk), .reset(reset), .pixelTick(pixel_tick), .pixelIn(pix_s),
    .nextX(next_x_s), .nextY(next_y_s), .pixelColour(colour_s),
    .hSync(hs_s), .vSync(vs_s), .videoActive(act_s), .frameDone(fd_s)
  );

  pixel_scan_controller dut_b (
    .clk(clk), .reset(reset), .pixelTick(pixel_tick), .pixelIn(pix_b),
    .nextX(next_x_b), .nextY(next_y_b), .pixelColour(colour_b),
    .hSync(hs_b), .vSync(vs_b), .videoActive(act_b), .frameDone(fd_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare(input string tag, input exp_t a, input exp_t e);
    check({tag, ".pixelColour"}, 32'(a.colour), 32'(e.colour));
    check({tag, ".videoActive"}, 32'(a.vact), 32'(e.vact));
    check({tag, ".hSync"},       32'(a.hs), 32'(e.hs));
    check({tag, ".vSync"},       32'(a.vs), 32'(e.vs));
    check({tag, ".frameDone"},   32'(a.fd), 32'(e.fd));
    check({tag, ".nextX"},       32'(a.x), 32'(e.x));
    check({tag, ".nextY"},       32'(a.y), 32'(e.y));
  endtask

  function automatic exp_t cap_s();
    return '{colour: colour_s, vact: act_s, hs: hs_s, vs: vs_s, fd: fd_s,
             x: next_x_s, y: next_y_s};
  endfunction

  function automatic exp_t cap_b();
    return '{colour: colour_b, vact: act_b, hs: hs_b, vs: vs_b, fd: fd_b,
             x: next_x_b, y: next_y_b};
  endfunction

  // Expected display outputs and next coordinate after a tick at beam position (h, v).
  function automatic exp_t predict(input geom_t g, input int h, input int v, input bit gen);
    exp_t e;
    int   ht, vt;
    bit   act, h_end, v_end;
    ht       = g.ha + g.hfp + g.hsy + g.hbp;
    vt       = g.va + g.vfp + g.vsy + g.vbp;
    act      = (h < g.ha) && (v < g.va);
    h_end    = (h == ht - 1);
    v_end    = (v == vt - 1);
    e.colour = act ? (gen ? gen_pix(h, v) : 8'hA5) : 8'h00;
    e.vact   = act;
    e.hs     = !((h >= g.ha + g.hfp) && (h < g.ha + g.hfp + g.hsy));
    e.vs     = !((v >= g.va + g.vfp) && (v < g.va + g.vfp + g.vsy));
    e.fd     = h_end && v_end;
    e.x      = h_end ? 16'd0 : 16'(h + 1);
    e.y      = h_end ? (v_end ? 16'd0 : 16'(v + 1)) : 16'(v);
    return e;
  endfunction

  task automatic drive(input logic t);
    exp_t e;
    @(negedge clk);
    pixel_tick = t;
    if (t) begin
      e = predict(G_S, h_s, v_s, pix_mode);
      q_s.push_back(e);
      h_s = int'(e.x);
      v_s = int'(e.y);
      e = predict(G_B, h_b, v_b, 1'b1);
      q_b.push_back(e);
      h_b = int'(e.x);
      v_b = int'(e.y);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      t_s = pixel_tick;
      #1;
      if (t_s) begin
        if (q_s.size() == 0) begin
          check("sb_small_empty", 32'd1, 32'd0);
        end else begin
          e_s    = q_s.pop_front();
          last_s = e_s;
          compare("small", cap_s(), e_s);
        end
      end else begin
        e_s    = last_s;
        e_s.fd = 1'b0;
        compare("small_hold", cap_s(), e_s);
      end
      if (fd_s === 1'b1) fd_cnt_s++;
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      t_b = pixel_tick;
      #1;
      if (t_b) begin
        if (q_b.size() == 0) begin
          check("sb_big_empty", 32'd1, 32'd0);
        end else begin
          e_b    = q_b.pop_front();
          last_b = e_b;
          compare("big", cap_b(), e_b);
        end
      end else begin
        e_b    = last_b;
        e_b.fd = 1'b0;
        compare("big_hold", cap_b(), e_b);
      end
    end
  end

  initial begin
    reset      = 1'b1;
    pixel_tick = 1'b0;
    pix_mode   = 1'b0;
    h_s = 0; v_s = 0; h_b = 0; v_b = 0;
    last_s = RST_EXP;
    last_b = RST_EXP;
    #3;
    compare("small_por", cap_s(), RST_EXP);
    compare("big_por", cap_b(), RST_EXP);
    @(negedge clk);
    reset = 1'b0;

    // Two frames of continuous ticks: first with constant A5, then the generator pattern.
    for (int i = 0; i < 240; i++) begin
      if (i == 120) pix_mode = 1'b1;
      drive(1'b1);
    end
    @(posedge clk);
    #2;
    check("frameDone_count_2frames", 32'(fd_cnt_s), 32'd2);

    // Gapped ticks 1,0,0,1; the lead-in tick puts the frame wrap just before a 0-tick cycle.
    drive(1'b1);
    for (int i = 0; i < 60; i++) begin
      drive(1'b1);
      drive(1'b0);
      drive(1'b0);
      drive(1'b1);
    end

    // Reset while the small instance is inside horizontal sync.
    while (h_s != 11) drive(1'b1);
    @(posedge clk);
    #2;
    check("small_hsync_before_reset", 32'(hs_s), 32'd0);
    reset = 1'b1;
    #1;
    compare("small_async_reset", cap_s(), RST_EXP);
    compare("big_async_reset", cap_b(), RST_EXP);
    h_s = 0; v_s = 0; h_b = 0; v_b = 0;
    last_s = RST_EXP;
    last_b = RST_EXP;
    @(negedge clk);
    pixel_tick = 1'b0;
    reset      = 1'b0;

    // Resume from (0,0); covers two full 800-tick lines of the default geometry.
    for (int i = 0; i < 1700; i++) drive(1'b1);
    @(posedge clk);
    #2;
    check("small_queue_drained", 32'(q_s.size()), 32'd0);
    check("big_queue_drained", 32'(q_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_scan_controller.md
# pixel_scan_controller

Raster scan controller that drives `PixelGenerationLogic`. Each pixel tick it steps the horizontal and vertical counters and presents the current coordinate on `nextX`/`nextY`. It samples the combinational colour returned on `pixelIn` and registers it, together with the sync and blanking flags, so all display outputs are cycle-aligned. It also emits a once-per-frame pulse that the game-state logic uses to update paddle and ball positions.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in ticks
- `H_SYNC`, 96: horizontal sync width, in ticks
- `H_BP`, 48: horizontal back porch, in ticks
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `SYNC_POL`, 0: asserted level of `hSync`/`vSync` (0 = active-low)
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `pixelTick`  in  1  pixel-rate enable; counters and display outputs advance only when this is 1
- `pixelIn`  in  8  colour from the pixel generator for the coordinate currently on `nextX`/`nextY`
- `nextX`  out  16 (signed)  current horizontal count, zero-extended
- `nextY`  out  16 (signed)  current vertical count, zero-extended
- `pixelColour`  out  8  registered colour to the DAC
- `hSync`  out  1  registered horizontal sync
- `vSync`  out  1  registered vertical sync
- `videoActive`  out  1  registered flag: `pixelColour` is a visible pixel
- `frameDone`  out  1  one-`clk` pulse at frame wrap

## Operation
- Derived constants:
  - `H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP`
  - `V_TOTAL` is defined the same way from the vertical parameters.
  - Counter width is ceil(log2(max total)), checked at elaboration to be ≤ 15 bits.
- Counters `hCount` and `vCount`, evaluated on a `clk` edge with `pixelTick` = 1:
  - `hCount` increments each tick and wraps to 0 after `H_TOTAL-1`.
  - On an `hCount` wrap, `vCount` increments and wraps to 0 after `V_TOTAL-1`.
  - With `pixelTick` = 0 all counters and display outputs hold.
- `nextX = {0, hCount}` and `nextY = {0, vCount}`, driven directly from the counter registers. No coordinate arithmetic is performed.
- Active region: `active = (hCount < H_ACTIVE) && (vCount < V_ACTIVE)`.
- Horizontal sync window: `H_ACTIVE+H_FP <= hCount < H_ACTIVE+H_FP+H_SYNC`. The vertical window is defined the same way on `vCount`.
- Output stage, loaded on a ticked edge:
  - `pixelColour <= active ? pixelIn : 0`
  - `videoActive <= active`
  - `hSync <= inHsyncWindow ? SYNC_POL : ~SYNC_POL`, with `vSync` formed likewise.
- `frameDone` is 1 for exactly one `clk` cycle. It follows the ticked edge on which the counters wrap from (`H_TOTAL-1`, `V_TOTAL-1`) to (0,0), and is cleared on the next `clk` edge regardless of `pixelTick`.
- Reset, applied asynchronously at any time (including mid-line or mid-sync):
  - `hCount`, `vCount`, `pixelColour`, `videoActive` and `frameDone` go to 0.
  - `hSync` and `vSync` go to `~SYNC_POL`.
  - After reset deassertion the first ticked edge produces the output for (0,0), and scanning restarts at (0,0).

## Timing
- Latency from a coordinate appearing on `nextX`/`nextY` to the matching `pixelColour`/`hSync`/`vSync`/`videoActive` is one tick. All display outputs share this latency and are therefore mutually aligned.
- `pixelIn` must settle within one `clk` period of the counter update. The generator is combinational on `nextX`/`nextY`.
- `pixelTick` may be held at 1 permanently, giving a pixel rate equal to `clk`. Non-periodic ticks are legal: the output sequence is identical, only stretched in time.
- Frame period is `H_TOTAL*V_TOTAL` ticks. `frameDone` rises at the start of visible line 0, which gives game logic the full frame to update before the next `nextY = 0` scan.

## Test plan
Scenarios 1–5 use small parameters: H 8/2/3/2 (`H_TOTAL` = 15), V 4/1/2/1 (`V_TOTAL` = 8), `SYNC_POL` = 0, `pixelTick` = 1.
1. Reset, then 15 ticks → `nextX` steps 0..14 then 0, and `nextY` goes 0→1 on the wrap. `hSync` = 0 on the outputs registered for `hCount` 10..12, i.e. visible one tick later; `hSync` = 1 elsewhere.
2. Hold `pixelIn` = 8'hA5 → `pixelColour` = A5 with `videoActive` = 1 for ticks whose `hCount` < 8 and `vCount` < 4. Otherwise `pixelColour` = 0 with `videoActive` = 0.
3. Run 2 frames → `frameDone` pulses exactly twice, 120 ticks apart, each 1 `clk` wide. `vSync` is low for 2 lines (30 ticks) per frame, starting at `vCount` = 5.
4. Toggle `pixelTick` 1,0,0,1 → the counters and outputs advance twice over 4 clocks. A `frameDone` pulse landing on a 0-tick cycle still lasts 1 `clk`.
5. Assert `reset` while `hCount` = 11 (inside sync) → on the same cycle, without a clock edge, `hSync` = 1, `vSync` = 1, `pixelColour` = 0 and `nextX`/`nextY` = 0. The scan resumes from (0,0).
6. Default 640x480 parameters, driving `pixelIn` with the reference generator model → `pixelColour` matches the model at every visible (x,y) of one frame, and `frameDone` fires once per frame, 800*525 ticks apart.
